// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with two prioritised
// write ports, optional write-to-read bypass, a write-collision flag and a
// hardware clear sweep engine (IDLE -> SWEEP -> DONE).
// Optional feature macro: REGFILE_ZERO_REG_EN (entry 0 hardwired to zero).
module regfile_mp #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4,
   parameter int NUM_RD = 2,
   parameter int BYPASS = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic                     clr_req,
   output logic                     clr_busy,
   output logic                     clr_done,
   output logic                     wr_conflict
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

`ifdef REGFILE_ZERO_REG_EN
   localparam bit ZERO_REG = 1'b1;
`else
   localparam bit ZERO_REG = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   idx;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                wr_open;
   logic                we0, we1;
   logic                conflict_nxt;
   logic [ADDR_W-1:0]   rd_a;
   logic [DATA_W-1:0]   rd_d;

   // Effective write enables: ports are closed during the sweep, wr1 wins a
   // same-address collision, and address 0 is dropped when it is hardwired.
   always_comb begin
      wr_open      = (state != SWEEP);
      we1          = wr1_en && wr_open && !(ZERO_REG && (wr1_addr == '0));
      we0          = wr0_en && wr_open && !(ZERO_REG && (wr0_addr == '0))
                     && !(wr1_en && (wr1_addr == wr0_addr));
      conflict_nxt = wr_open && wr0_en && wr1_en && (wr0_addr == wr1_addr)
                     && !(ZERO_REG && (wr0_addr == '0));
   end

   // FSM state and sweep index register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && clr_req)
            idx <= '0;
         else if (state == SWEEP)
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
   end

   // Next-state decode and status outputs.
   always_comb begin
      state_nxt = state;
      clr_busy  = 1'b0;
      clr_done  = 1'b0;
      unique case (state)
         IDLE:  if (clr_req) state_nxt = SWEEP;
         SWEEP: begin
            clr_busy = 1'b1;
            if (idx == LAST_IDX) state_nxt = DONE;
         end
         DONE: begin
            clr_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Storage: async clear on reset, one entry zeroed per sweep cycle,
   // otherwise port writes (we0/we1 never target the same entry).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (state == SWEEP) begin
         mem[idx] <= '0;
      end else begin
         if (we0) mem[wr0_addr] <= wr0_data;
         if (we1) mem[wr1_addr] <= wr1_data;
      end
   end

   // Collision flag, registered so it shows the cycle after the collision.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         wr_conflict <= 1'b0;
      else
         wr_conflict <= conflict_nxt;
   end

   // Combinational read ports with optional same-cycle forwarding; wr1 is
   // applied last so it overrides wr0 on an address match.
   always_comb begin
      rd_data = '0;
      rd_a    = '0;
      rd_d    = '0;
      for (int unsigned k = 0; k < NUM_RD; k++) begin
         rd_a = rd_addr[k*ADDR_W +: ADDR_W];
         rd_d = mem[rd_a];
         if (BYPASS != 0) begin
            if (we0 && (wr0_addr == rd_a)) rd_d = wr0_data;
            if (we1 && (wr1_addr == rd_a)) rd_d = wr1_data;
         end
         if (ZERO_REG && (rd_a == '0)) rd_d = '0;
         rd_data[k*DATA_W +: DATA_W] = rd_d;
      end
   end

endmodule
